// File: rtl/ggt_param_if.sv
// Request/response bundle for the gcd engine: operands and mode in, result, iteration count and
// status out.
interface ggt_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ITER_W = 8
);
  logic              start_i;
  logic              mode_i;
  logic [WIDTH-1:0]  Zahl1_i;
  logic [WIDTH-1:0]  Zahl2_i;
  logic              busy_o;
  logic              valid_o;
  logic [WIDTH-1:0]  ergebnis_o;
  logic [ITER_W-1:0] iter_o;

  modport master (
    output start_i, mode_i, Zahl1_i, Zahl2_i,
    input  busy_o, valid_o, ergebnis_o, iter_o
  );

  modport slave (
    input  start_i, mode_i, Zahl1_i, Zahl2_i,
    output busy_o, valid_o, ergebnis_o, iter_o
  );
endinterface

// File: rtl/ggt_param.sv
// Iterative gcd engine: subtractive Euclid (mode 0) or binary Stein (mode 1), one step per clock,
// with a saturating count of the steps taken.
module ggt_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ITER_W = 8
) (
  input  logic       clk,
  input  logic       rst_i,
  ggt_param_if.slave bus
);
  localparam int unsigned KW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              m_q;
  logic [KW-1:0]     k_q;
  logic [ITER_W-1:0] cnt_q, iter_q, cnt_inc;
  logic              busy_q, valid_q;

  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ITER_W'(1);
  end

  assign bus.busy_o     = busy_q;
  assign bus.valid_o    = valid_q;
  assign bus.ergebnis_o = res_q;
  assign bus.iter_o     = iter_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start_i) begin
            a_q    <= bus.Zahl1_i;
            b_q    <= bus.Zahl2_i;
            m_q    <= bus.mode_i;
            k_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            // A zero operand short-circuits: gcd(0,x) = x without any CALC step.
            if (bus.Zahl1_i == '0 || bus.Zahl2_i == '0) begin
              res_q   <= bus.Zahl1_i | bus.Zahl2_i;
              iter_q  <= '0;
              valid_q <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StCalc: begin
          cnt_q <= cnt_inc;
          if (a_q == b_q) begin
            res_q   <= m_q ? (a_q << k_q) : a_q;
            iter_q  <= cnt_inc;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else if (!m_q) begin
            if (a_q > b_q) a_q <= a_q - b_q;
            else           b_q <= b_q - a_q;
          end else if (!a_q[0] && !b_q[0]) begin
            // Common factor of two: remember it in k and restore it on the final result.
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule
